// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared types and constants for the data-bus splitter
package dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dbus_state_e;

  localparam logic [31:0] DBUS_ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [31:0] DBUS_SEL_MASK = 32'hF000_0000;
  localparam logic [31:0] DBUS_SEL_BASE = 32'h1000_0000;

endpackage

// File: rtl/dbus_addr_decode.sv
// rtl/dbus_addr_decode.sv - address to target select decode (1 = MMIO)
module dbus_addr_decode
  import dbus_pkg::*;
#(
  parameter logic [31:0] SEL_MASK = DBUS_SEL_MASK,
  parameter logic [31:0] SEL_BASE = DBUS_SEL_BASE
) (
  input  logic [31:0] addr,
  output logic        sel
);

  assign sel = ((addr & SEL_MASK) == SEL_BASE);

endmodule

// File: rtl/dbus_split2.sv
// rtl/dbus_split2.sv - one-outstanding data-bus splitter to RAM / MMIO targets
module dbus_split2
  import dbus_pkg::*;
#(
  parameter logic [31:0] SEL_MASK = DBUS_SEL_MASK,
  parameter logic [31:0] SEL_BASE = DBUS_SEL_BASE,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        t0_valid,
  input  logic        t0_ready,
  output logic [31:0] t0_addr,
  output logic [31:0] t0_wdata,
  output logic        t0_we,
  output logic [3:0]  t0_be,
  input  logic        t0_rsp_valid,
  input  logic [31:0] t0_rsp_rdata,
  output logic        t1_valid,
  input  logic        t1_ready,
  output logic [31:0] t1_addr,
  output logic [31:0] t1_wdata,
  output logic        t1_we,
  output logic [3:0]  t1_be,
  input  logic        t1_rsp_valid,
  input  logic [31:0] t1_rsp_rdata
);

  // Counter value in the last ISSUE/WAIT cycle before the error response.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  dbus_state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic        sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        sel_dec;
  logic        t_ready;
  logic        t_rsp;
  logic [31:0] t_rdata;
  logic        timed_out;

  dbus_addr_decode #(
    .SEL_MASK (SEL_MASK),
    .SEL_BASE (SEL_BASE)
  ) u_decode (
    .addr (req_addr),
    .sel  (sel_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Only the latched target is observed; the other target's signals are ignored.
  assign t_ready   = sel_q ? t1_ready     : t0_ready;
  assign t_rsp     = sel_q ? t1_rsp_valid : t0_rsp_valid;
  assign t_rdata   = sel_q ? t1_rsp_rdata : t0_rsp_rdata;
  assign timed_out = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    be_d    = be_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          be_d    = req_be;
          sel_d   = sel_dec;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + 16'd1;
        // A response completes the transaction even in the final timeout cycle.
        if (t_ready && t_rsp) begin
          rdata_d = t_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timed_out) begin
          rdata_d = DBUS_ERR_DATA;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (t_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (t_rsp) begin
          rdata_d = t_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timed_out) begin
          rdata_d = DBUS_ERR_DATA;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    t0_valid  = (state_q == ST_ISSUE) && !sel_q;
    t1_valid  = (state_q == ST_ISSUE) &&  sel_q;
    t0_addr   = addr_q;
    t0_wdata  = wdata_q;
    t0_we     = we_q;
    t0_be     = be_q;
    t1_addr   = addr_q;
    t1_wdata  = wdata_q;
    t1_we     = we_q;
    t1_be     = be_q;
  end

endmodule

// File: tb/tb_dbus_split2.sv
// tb/tb_dbus_split2.sv - directed self-checking bench for dbus_split2
module tb_dbus_split2;
  import dbus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        t0_valid, t0_ready, t0_we, t0_rsp_valid;
  logic [31:0] t0_addr, t0_wdata, t0_rsp_rdata;
  logic [3:0]  t0_be;
  logic        t1_valid, t1_ready, t1_we, t1_rsp_valid;
  logic [31:0] t1_addr, t1_wdata, t1_rsp_rdata;
  logic [3:0]  t1_be;

  int n_total;
  int n_bad;

  dbus_split2 #(
    .SEL_MASK (DBUS_SEL_MASK),
    .SEL_BASE (DBUS_SEL_BASE),
    .TIMEOUT  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_we       (req_we),
    .req_be       (req_be),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .t0_valid     (t0_valid),
    .t0_ready     (t0_ready),
    .t0_addr      (t0_addr),
    .t0_wdata     (t0_wdata),
    .t0_we        (t0_we),
    .t0_be        (t0_be),
    .t0_rsp_valid (t0_rsp_valid),
    .t0_rsp_rdata (t0_rsp_rdata),
    .t1_valid     (t1_valid),
    .t1_ready     (t1_ready),
    .t1_addr      (t1_addr),
    .t1_wdata     (t1_wdata),
    .t1_we        (t1_we),
    .t1_be        (t1_be),
    .t1_rsp_valid (t1_rsp_valid),
    .t1_rsp_rdata (t1_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle N; returns positioned in cycle N+1.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] b);
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_we    = w;
    req_be    = b;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_we = 1'b0; req_be = '0;
    t0_ready = 1'b0; t0_rsp_valid = 1'b0; t0_rsp_rdata = '0;
    t1_ready = 1'b0; t1_rsp_valid = 1'b0; t1_rsp_rdata = '0;
    repeat (2) step();

    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    chk("rst_t0_valid",  {31'd0, t0_valid}, 32'd0);
    chk("rst_t1_valid",  {31'd0, t1_valid}, 32'd0);
    chk("rst_t0_addr",   t0_addr, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Read to RAM, typical latency
    send(32'h0000_0040, 32'h0, 1'b0, 4'hF);
    chk("rd_t0_valid", {31'd0, t0_valid}, 32'd1);
    chk("rd_t1_valid", {31'd0, t1_valid}, 32'd0);
    chk("rd_t0_addr",  t0_addr, 32'h0000_0040);
    chk("rd_busy",     {31'd0, req_ready}, 32'd0);
    t0_ready = 1'b1;
    step();
    t0_ready = 1'b0;
    chk("rd_wait_t0_valid", {31'd0, t0_valid}, 32'd0);
    chk("rd_wait_rsp",      {31'd0, rsp_valid}, 32'd0);
    chk("rd_wait_t1_valid", {31'd0, t1_valid}, 32'd0);
    t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'h1234_5678;
    step();
    t0_rsp_valid = 1'b0;
    chk("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd_rsp_err",   {31'd0, rsp_err}, 32'd0);
    chk("rd_rsp_busy",  {31'd0, req_ready}, 32'd0);
    step();
    chk("rd_pulse_end", {31'd0, rsp_valid}, 32'd0);

    // Write to MMIO
    send(32'h1000_0004, 32'hA5A5_0F0F, 1'b1, 4'b0011);
    chk("wr_t1_valid", {31'd0, t1_valid}, 32'd1);
    chk("wr_t0_valid", {31'd0, t0_valid}, 32'd0);
    chk("wr_t1_addr",  t1_addr, 32'h1000_0004);
    chk("wr_t1_wdata", t1_wdata, 32'hA5A5_0F0F);
    chk("wr_t1_we",    {31'd0, t1_we}, 32'd1);
    chk("wr_t1_be",    {28'd0, t1_be}, 32'h3);
    t1_ready = 1'b1;
    step();
    t1_ready = 1'b0;
    t1_rsp_valid = 1'b1; t1_rsp_rdata = 32'h0;
    step();
    t1_rsp_valid = 1'b0;
    chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_rsp_err",   {31'd0, rsp_err}, 32'd0);
    step();

    // Same-cycle ready and response on t1
    send(32'h1000_0100, 32'h0, 1'b0, 4'hF);
    chk("sc_t1_valid", {31'd0, t1_valid}, 32'd1);
    t1_ready = 1'b1; t1_rsp_valid = 1'b1; t1_rsp_rdata = 32'hCAFE_F00D;
    step();
    t1_ready = 1'b0; t1_rsp_valid = 1'b0;
    chk("sc_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sc_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    step();
    chk("sc_idle_ready", {31'd0, req_ready}, 32'd1);

    // Spurious response from the non-selected target
    send(32'h1000_0008, 32'h0, 1'b0, 4'hF);
    t1_ready = 1'b1;
    step();
    t1_ready = 1'b0;
    t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'hFFFF_FFFF;
    step();
    t0_rsp_valid = 1'b0;
    chk("sp_ignored", {31'd0, rsp_valid}, 32'd0);
    t1_rsp_valid = 1'b1; t1_rsp_rdata = 32'h0000_0001;
    step();
    t1_rsp_valid = 1'b0;
    chk("sp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sp_rsp_rdata", rsp_rdata, 32'h0000_0001);
    chk("sp_rsp_err",   {31'd0, rsp_err}, 32'd0);
    step();

    // Timeout on t0 (TIMEOUT=8): ISSUE in N+1..N+8, error in N+9
    send(32'h0000_0100, 32'h0, 1'b0, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("to_t0_valid_%0d", k), {31'd0, t0_valid}, 32'd1);
      chk($sformatf("to_no_rsp_%0d", k),   {31'd0, rsp_valid}, 32'd0);
      step();
    end
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_rsp_err",   {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata, DBUS_ERR_DATA);
    chk("to_t0_low",    {31'd0, t0_valid}, 32'd0);
    step();
    chk("to_idle", {31'd0, req_ready}, 32'd1);

    // Reset asserted while in WAIT
    send(32'h0000_0080, 32'h5555_AAAA, 1'b1, 4'hF);
    t0_ready = 1'b1;
    step();
    t0_ready = 1'b0;
    chk("rw_in_wait", {31'd0, req_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rw_rsp_rdata", rsp_rdata, 32'd0);
    chk("rw_rsp_err",   {31'd0, rsp_err}, 32'd0);
    chk("rw_t0_valid",  {31'd0, t0_valid}, 32'd0);
    chk("rw_t0_addr",   t0_addr, 32'd0);
    chk("rw_t0_wdata",  t0_wdata, 32'd0);
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
    t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'h0BAD_0BAD;
    step();
    t0_rsp_valid = 1'b0;
    chk("rw_late_ignored", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("rw_late_still", {31'd0, rsp_valid}, 32'd0);

    // Minimum-latency transaction after reset
    send(32'h0000_0200, 32'h0, 1'b0, 4'hF);
    chk("ml_t0_valid", {31'd0, t0_valid}, 32'd1);
    t0_ready = 1'b1; t0_rsp_valid = 1'b1; t0_rsp_rdata = 32'h7777_0001;
    step();
    t0_ready = 1'b0; t0_rsp_valid = 1'b0;
    chk("ml_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ml_rsp_rdata", rsp_rdata, 32'h7777_0001);
    chk("ml_rsp_err",   {31'd0, rsp_err}, 32'd0);
    step();
    chk("ml_idle", {31'd0, req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_split2.md
# dbus_split2

Data-bus address splitter for the RV32I core. It accepts one load/store request from the core's single data-bus initiator port and decodes the address. It forwards the request to one of two targets (target 0 = data RAM, target 1 = MMIO region), then returns that target's response to the core. It is the routing counterpart of the core's 2:1 result-select path, with one outstanding transaction, a registered request and a response timeout.

## Interface
- `SEL_MASK`, default 32'hF000_0000: address bits compared for target 1 decode.
- `SEL_BASE`, default 32'h1000_0000: `(addr & SEL_MASK) == SEL_BASE` selects target 1; otherwise target 0.
- `TIMEOUT`, default 255: maximum cycles spent in ISSUE+WAIT before an error response (1..65535).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1 / `req_ready` out 1: core request handshake.
- `req_addr` in 32, `req_wdata` in 32, `req_we` in 1, `req_be` in 4: request payload.
- `rsp_valid` out 1, `rsp_rdata` out 32, `rsp_err` out 1: response to the core, one-cycle pulse.
- `tN_valid` out 1, `tN_ready` in 1 (N = 0, 1): target request handshake.
- `tN_addr` out 32, `tN_wdata` out 32, `tN_we` out 1, `tN_be` out 4: target payload, driven from the request register.
- `tN_rsp_valid` in 1, `tN_rsp_rdata` in 32: target response, which is the acknowledge for both reads and writes.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, capture addr/wdata/we/be into the request register and latch `sel` (the decoded target).
  - Clear the timeout counter and go to ISSUE.
- ISSUE
  - `t[sel]_valid`=1; the other target's valid stays 0.
  - On `t[sel]_ready`, go to WAIT.
  - If `t[sel]_rsp_valid` is also 1 in the same cycle, capture the response and go directly to RESP.
- WAIT
  - On `t[sel]_rsp_valid`, capture `rsp_rdata`, set `rsp_err`=0 and go to RESP.
- RESP
  - `rsp_valid`=1 for exactly one cycle, then go to IDLE.
- Timeout
  - The counter increments every cycle in ISSUE or WAIT.
  - When it reaches `TIMEOUT` before completion: go to RESP with `rsp_rdata`=32'hDEAD_BEEF and `rsp_err`=1.
  - `t[sel]_valid` drops on the transition out of ISSUE.
- Ignored inputs:
  - `rsp_valid` from the non-selected target.
  - `rsp_valid` from any target in IDLE or RESP.
- Target payload outputs carry the request register in all states. They are meaningful only while the matching `tN_valid` is 1.
- Reset mid-transaction: return to IDLE immediately and discard the transaction. A target's late response is ignored.
- Reset values:
  - state=IDLE, `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `t0_valid`=`t1_valid`=0.
  - Request register=0, `sel`=0, counter=0.

## Timing
- Request accepted at edge of cycle N; `t[sel]_valid`=1 in cycle N+1.
- Minimum latency: ready and rsp_valid both in N+1 gives `rsp_valid` in N+2.
- Typical latency: ready in N+1 and rsp_valid in N+2 gives `rsp_valid` in N+3.
- `req_ready`=0 from N+1 until the cycle after RESP. The next request can be accepted in the cycle following RESP (back-to-back period ≥3 cycles).
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Timeout: with no ready/response, `rsp_err` pulses in cycle N+1+TIMEOUT.

## Structure
- Shared package `dbus_pkg`:
  - State enum.
  - `DBUS_ERR_DATA` = 32'hDEAD_BEEF.
  - Default `SEL_BASE`/`SEL_MASK` constants, reused by the MMIO decoder and the testbench.
- One natural sub-module: `dbus_addr_decode`, a combinational address→`sel` function instantiated once at the capture point.

## Test plan
- Read to RAM: req addr 0x0000_0040; t0 ready in N+1, rsp 0x1234_5678 in N+2 → `rsp_valid` in N+3, rdata 0x1234_5678, err 0, t1_valid never 1.
- Write to MMIO: addr 0x1000_0004, we=1, be=4'b0011, wdata 0xA5A5_0F0F → t1 sees identical payload; ack → `rsp_valid`, err 0.
- Same-cycle ready+response in ISSUE on t1 → `rsp_valid` in N+2, WAIT skipped.
- Spurious response: t0 pulses rsp 0xFFFF_FFFF while sel=1 is in WAIT → ignored; the later t1 rsp 0x0000_0001 is returned.
- Timeout: TIMEOUT=8, t0 never ready → `rsp_valid` with err 1, rdata 0xDEAD_BEEF in cycle N+9; `t0_valid` low after.
- Reset asserted in WAIT → all outputs at reset values asynchronously. A target response after reset release produces no `rsp_valid`, and the next request completes normally.
